// File: rtl/ita_act_pipe.sv
// Multi-lane activation (identity / ReLU / i-GELU) plus ITA requantisation.
// Three-stage valid/ready pipeline with a sticky saturation event counter.
module ita_act_pipe #(
    parameter int unsigned N_LANES = 16,
    parameter int unsigned WI      = 8,
    parameter int unsigned EMS     = 8,
    parameter int unsigned CW      = 16,
    parameter int unsigned PW      = 32,
    parameter int unsigned SCW     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [N_LANES*WI-1:0] data_i,
    input  logic [1:0]            mode_i,
    input  logic [CW-1:0]         one_i,
    input  logic [CW-1:0]         b_i,
    input  logic [CW-1:0]         c_i,
    input  logic [EMS-1:0]        eps_mult_i,
    input  logic [EMS-1:0]        right_shift_i,
    input  logic [WI-1:0]         add_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [N_LANES*WI-1:0] data_o,
    input  logic                  clear_i,
    output logic [SCW-1:0]        sat_count_o
);

    localparam int unsigned DW   = N_LANES * WI;
    localparam int unsigned RW   = PW + EMS;
    localparam int unsigned CNTW = $clog2(N_LANES + 1);

    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_GELU = 2'd2;

    localparam logic [WI-1:0]        X_MIN   = {1'b1, {(WI-1){1'b0}}};
    localparam logic signed [RW:0]   SAT_MAX = (RW+1)'((1 << (WI - 1)) - 1);
    localparam logic signed [RW:0]   SAT_MIN = -SAT_MAX - (RW+1)'(1);

    // Stage-1 value: GELU polynomial L, or the final p for identity/ReLU.
    function automatic logic signed [PW-1:0] act_l(input logic [WI-1:0] x,
                                                   input logic [1:0]    mode,
                                                   input logic [CW-1:0] b,
                                                   input logic [CW-1:0] c);
        logic signed [PW-1:0] xe, a, nb, t;
        xe    = PW'($signed(x));
        nb    = -PW'($signed(b));
        a     = x[WI-1] ? -xe : xe;
        t     = '0;
        act_l = xe;
        if (mode == MODE_RELU) begin
            act_l = x[WI-1] ? '0 : xe;
        end else if (mode == MODE_GELU) begin
            // most negative input is clipped by one so |x| stays representable
            if (x == X_MIN) a = a - PW'(1);
            if (a > nb) a = nb;
            t     = a + PW'($signed(b));
            act_l = t * t + PW'($signed(c));
        end
    endfunction

    function automatic logic signed [RW-1:0] act_prod(input logic signed [PW-1:0] l,
                                                      input logic [WI-1:0]         x,
                                                      input logic [1:0]            mode,
                                                      input logic [CW-1:0]         one,
                                                      input logic [EMS-1:0]        eps);
        logic signed [PW-1:0] sl, p;
        sl       = x[WI-1] ? -l : l;
        p        = (mode == MODE_GELU) ? PW'($signed(x)) * (sl + PW'($signed(one))) : l;
        act_prod = RW'(p) * RW'($signed({1'b0, eps}));
    endfunction

    // Returns {saturated, result}.
    function automatic logic [WI:0] requant(input logic signed [RW-1:0] prod,
                                            input logic [EMS-1:0]        shift,
                                            input logic [WI-1:0]         add);
        logic signed [RW:0] sh, r;
        logic               rnd;
        sh  = (RW+1)'(prod) >>> shift;
        rnd = 1'(prod >> (shift - EMS'(1)));
        if ((shift != '0) && rnd) sh = sh + (RW+1)'(1);
        r = sh + (RW+1)'($signed(add));
        if (r > SAT_MAX)      requant = {1'b1, 1'b0, {(WI-1){1'b1}}};
        else if (r < SAT_MIN) requant = {1'b1, X_MIN};
        else                  requant = {1'b0, r[WI-1:0]};
    endfunction

    logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [DW-1:0]        x1_q, x1_d;
    logic signed [PW-1:0] l1_q [N_LANES];
    logic signed [PW-1:0] l1_d [N_LANES];
    logic [1:0]           mode1_q, mode1_d;
    logic [CW-1:0]        one1_q, one1_d;
    logic [EMS-1:0]       eps1_q, eps1_d, shift1_q, shift1_d;
    logic [WI-1:0]        add1_q, add1_d;
    logic signed [RW-1:0] prod2_q [N_LANES];
    logic signed [RW-1:0] prod2_d [N_LANES];
    logic [EMS-1:0]       shift2_q, shift2_d;
    logic [WI-1:0]        add2_q, add2_d;
    logic [DW-1:0]        data3_q, data3_d;
    logic [N_LANES-1:0]   sat3_q, sat3_d;
    logic [SCW-1:0]       cnt_q, cnt_d;

    logic                 en1, en2, en3, fire;
    logic [WI:0]          rq [N_LANES];
    logic [CNTW-1:0]      nsat;
    logic [SCW-1:0]       cnt_base;
    logic [SCW:0]         cnt_sum;

    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            rq[k] = requant(prod2_q[k], shift2_q, add2_q);
        end
    end

    // Elastic control and per-stage next-state.
    always_comb begin
        en3  = ~v3_q | ready_i;
        en2  = ~v2_q | en3;
        en1  = ~v1_q | en2;
        fire = v3_q & ready_i;

        v1_d     = en1 ? valid_i : v1_q;
        v2_d     = en2 ? v1_q : v2_q;
        v3_d     = en3 ? v2_q : v3_q;
        x1_d     = x1_q;
        l1_d     = l1_q;
        mode1_d  = mode1_q;
        one1_d   = one1_q;
        eps1_d   = eps1_q;
        shift1_d = shift1_q;
        add1_d   = add1_q;
        prod2_d  = prod2_q;
        shift2_d = shift2_q;
        add2_d   = add2_q;
        data3_d  = data3_q;
        sat3_d   = sat3_q;

        if (en1 && valid_i) begin
            x1_d     = data_i;
            mode1_d  = mode_i;
            one1_d   = one_i;
            eps1_d   = eps_mult_i;
            shift1_d = right_shift_i;
            add1_d   = add_i;
            for (int k = 0; k < N_LANES; k++) begin
                l1_d[k] = act_l(data_i[k*WI +: WI], mode_i, b_i, c_i);
            end
        end
        if (en2 && v1_q) begin
            shift2_d = shift1_q;
            add2_d   = add1_q;
            for (int k = 0; k < N_LANES; k++) begin
                prod2_d[k] = act_prod(l1_q[k], x1_q[k*WI +: WI], mode1_q, one1_q, eps1_q);
            end
        end
        if (en3 && v2_q) begin
            for (int k = 0; k < N_LANES; k++) begin
                data3_d[k*WI +: WI] = rq[k][WI-1:0];
                sat3_d[k]           = rq[k][WI];
            end
        end

        // Clear wins over the old count but not over the beat leaving this cycle.
        nsat = '0;
        for (int k = 0; k < N_LANES; k++) begin
            nsat = nsat + CNTW'(sat3_q[k]);
        end
        cnt_base = clear_i ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + (fire ? (SCW+1)'(nsat) : '0);
        cnt_d    = cnt_sum[SCW] ? '1 : cnt_sum[SCW-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            x1_q     <= '0;
            l1_q     <= '{default: '0};
            mode1_q  <= '0;
            one1_q   <= '0;
            eps1_q   <= '0;
            shift1_q <= '0;
            add1_q   <= '0;
            prod2_q  <= '{default: '0};
            shift2_q <= '0;
            add2_q   <= '0;
            data3_q  <= '0;
            sat3_q   <= '0;
            cnt_q    <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            v3_q     <= v3_d;
            x1_q     <= x1_d;
            l1_q     <= l1_d;
            mode1_q  <= mode1_d;
            one1_q   <= one1_d;
            eps1_q   <= eps1_d;
            shift1_q <= shift1_d;
            add1_q   <= add1_d;
            prod2_q  <= prod2_d;
            shift2_q <= shift2_d;
            add2_q   <= add2_d;
            data3_q  <= data3_d;
            sat3_q   <= sat3_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o     = en1;
    assign valid_o     = v3_q;
    assign data_o      = data3_q;
    assign sat_count_o = cnt_q;

endmodule

// File: tb/tb_ita_act_pipe.sv
// Scoreboard bench for ita_act_pipe: directed beats, randomised backpressure stream, reset flush.
module tb_ita_act_pipe;

    localparam int N  = 16;
    localparam int WI = 8;
    localparam int DW = N * WI;

    typedef struct {
        logic [DW-1:0] data;
        logic [N-1:0]  sat;
        bit            chk0;
        int            e0;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_i, valid_i, clear_i;
    logic          ready_o, valid_o;
    logic [DW-1:0] data_i, data_o;
    logic [1:0]    mode_i;
    logic [15:0]   one_i, b_i, c_i, sat_count_o;
    logic [7:0]    eps_mult_i, right_shift_i, add_i;
    bit            rdy_rand = 1'b0, rdy_force = 1'b1, rdy_pat = 1'b1;
    wire           ready_i = rdy_rand ? rdy_pat : rdy_force;

    int            n_vec = 0, n_err = 0;
    int            cyc = 0, bp_start = 0;
    exp_t          sb[$];
    int unsigned   exp_cnt = 0;
    logic [DW-1:0] prev_data;
    bit            prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;

    ita_act_pipe dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .mode_i(mode_i), .one_i(one_i), .b_i(b_i), .c_i(c_i),
        .eps_mult_i(eps_mult_i), .right_shift_i(right_shift_i), .add_i(add_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .clear_i(clear_i), .sat_count_o(sat_count_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        cyc++;
        rdy_pat = ((cyc - bp_start) inside {[6:10]}) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the activation + requant definition.
    function automatic int lane_model(input int x, input int mode, input int one, input int b,
                                      input int c, input int eps, input int sh, input int add,
                                      output bit sat);
        longint p, l, a, xc, prod, q, r;
        case (mode)
            1: p = (x < 0) ? 0 : x;
            2: begin
                xc = (x < -127) ? -127 : x;
                a  = (xc < 0) ? -xc : xc;
                if (a > -b) a = -b;
                l = (a + b) * (a + b) + c;
                p = x * (((x < 0) ? -l : l) + one);
            end
            default: p = x;
        endcase
        prod = p * eps;
        q    = prod >>> sh;
        if (sh > 0 && ((prod >>> (sh - 1)) & 1) != 0) q++;
        r   = q + add;
        sat = (r > 127) || (r < -128);
        return (r > 127) ? 127 : (r < -128) ? -128 : int'(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x0, input int mode, input int one, input int b, input int c,
                        input int eps, input int sh, input int add, input bit chk0, input int e0,
                        input int spread, input int x1, input bit set1);
        exp_t          e;
        bit            s, acc;
        int            xk;
        logic [DW-1:0] d;
        for (int k = 0; k < N; k++) begin
            if (k == 0)              xk = x0;
            else if (k == 1 && set1) xk = x1;
            else begin
                xk = int'($urandom_range(0, 2 * spread)) - spread;
                if (xk > 127) xk = 127;
            end
            d[k*WI +: WI]      = WI'(xk);
            e.data[k*WI +: WI] = WI'(lane_model(xk, mode, one, b, c, eps, sh, add, s));
            e.sat[k]           = s;
        end
        e.chk0 = chk0;
        e.e0   = e0;
        data_i = d; mode_i = 2'(mode); one_i = 16'(one); b_i = 16'(b); c_i = 16'(c);
        eps_mult_i = 8'(eps); right_shift_i = 8'(sh); add_i = 8'(add);
        valid_i = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back(e);
                acc = 1'b1;
                break;
            end
            step();
        end
        if (acc) step();
        valid_i = 1'b0;
        chk("accept_timeout", DW'(acc), DW'(1'b1));
    endtask

    task automatic drain();
        for (int t = 0; t < 80; t++) begin
            step();
            if (sb.size() == 0) break;
        end
        chk("drain_left", DW'(sb.size()), '0);
    endtask

    task automatic check_latency(input string tag);
        int lat;
        lat = 0;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = t;
                break;
            end
        end
        chk(tag, DW'(lat), DW'(3));
        step();
    endtask

    // Output monitor: scoreboard pop, stall stability, counter model.
    always @(negedge clk) begin
        exp_t          e;
        int            nsat;
        logic [WI-1:0] g0, x0v;
        if (rst_i) begin
            sb.delete();
            exp_cnt  = 0;
            prev_rst = 1'b1;
            prev_v   = 1'b0;
        end else begin
            chk("sat_count", DW'(sat_count_o), DW'(exp_cnt));
            if (!prev_rst && prev_v && !prev_r) begin
                chk("stall_valid", DW'(valid_o), DW'(1'b1));
                chk("stall_data", data_o, prev_data);
            end
            nsat = 0;
            if (valid_o && ready_i) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_out: got beat %0h expected none", data_o);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data", data_o, e.data);
                    if (e.chk0) begin
                        g0  = data_o[WI-1:0];
                        x0v = WI'(e.e0);
                        chk("lane0", DW'(g0), DW'(x0v));
                    end
                    nsat = $countones(e.sat);
                end
            end
            exp_cnt = (clear_i ? 0 : exp_cnt) + nsat;
            if (exp_cnt > 65535) exp_cnt = 65535;
            prev_rst  = 1'b0;
            prev_v    = valid_o;
            prev_r    = ready_i;
            prev_data = data_o;
        end
    end

    initial begin
        int md, one_r, b_r, c_r, eps_r, sh_r, add_r;
        rst_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0; data_i = '0; mode_i = '0;
        one_i = '0; b_i = '0; c_i = '0; eps_mult_i = '0; right_shift_i = '0; add_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_valid", DW'(valid_o), '0);
        chk("rst_data", data_o, '0);
        chk("rst_sat", DW'(sat_count_o), '0);
        chk("rst_ready", DW'(ready_o), DW'(1'b1));
        step();

        // Identity with rounding
        send(10, 0, 0, 0, 0, 3, 1, 0, 1, 15, 40, 0, 0);
        check_latency("latency");
        send(11, 0, 0, 0, 0, 3, 1, 0, 1, 17, 40, 0, 0);
        drain();

        // Saturation on two lanes, then clear
        clear_i = 1'b1; step(); clear_i = 1'b0;
        @(negedge clk);
        chk("sat_cleared0", DW'(sat_count_o), '0);
        step();
        send(100, 0, 0, 0, 0, 4, 0, 0, 1, 127, 20, -100, 1);
        drain();
        @(negedge clk);
        chk("sat_two", DW'(sat_count_o), DW'(2));
        step();
        clear_i = 1'b1; step(); clear_i = 1'b0;
        @(negedge clk);
        chk("sat_cleared1", DW'(sat_count_o), '0);
        step();

        // ReLU with offset
        send(-5, 1, 0, 0, 0, 1, 0, 7, 1, 7, 128, 0, 0);
        send(9, 1, 0, 0, 0, 1, 0, 7, 1, 16, 128, 0, 0);
        drain();

        // GELU, including the clipped most-negative input
        send(2, 2, 2, -4, 1, 1, 0, 0, 1, 14, 128, 0, 0);
        send(-3, 2, 2, -4, 1, 1, 0, 0, 1, 0, 128, 0, 0);
        send(6, 2, 2, -4, 1, 1, 0, 0, 1, 18, 128, 0, 0);
        send(-128, 2, 2, -4, 1, 1, 0, 0, 1, -128, 128, 0, 0);
        drain();

        // Backpressure stream with per-beat config
        bp_start = cyc;
        rdy_rand = 1'b1;
        for (int i = 0; i < 20; i++) begin
            md    = i % 4;
            one_r = int'($urandom_range(0, 100)) - 50;
            b_r   = -int'($urandom_range(1, 120));
            c_r   = int'($urandom_range(0, 200)) - 100;
            eps_r = int'($urandom_range(1, 127));
            sh_r  = int'($urandom_range(0, 12));
            add_r = int'($urandom_range(0, 255)) - 128;
            send(int'($urandom_range(0, 255)) - 128, md, one_r, b_r, c_r, eps_r, sh_r, add_r,
                 0, 0, 128, 0, 0);
        end
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;
        drain();

        // Fill under full stall, then reset mid-flight
        rdy_force = 1'b0;
        for (int i = 0; i < 3; i++) send(i * 7 - 10, 0, 0, 0, 0, 5, 1, 3, 0, 0, 128, 0, 0);
        @(negedge clk);
        chk("full_ready", DW'(ready_o), '0);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", DW'(valid_o), '0);
        chk("post_rst_sat", DW'(sat_count_o), '0);
        step();
        rdy_force = 1'b1;
        send(20, 0, 0, 0, 0, 2, 2, -1, 1, 9, 64, 0, 0);
        check_latency("post_rst_latency");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ita_act_pipe.md
# ita_act_pipe

Multi-lane, pipelined, mode-selectable activation and requantisation unit; the next generation of the ITA single-lane combinational GELU. Applies identity, ReLU or integer i-GELU, then the ITA requantisation (multiply, rounding shift, offset add, saturate) to `N_LANES` signed values per beat. It sits between the accumulator and output buffer of the feed-forward path. It uses a valid/ready elastic 3-stage pipeline and keeps a saturation event counter for debug/calibration.

## Interface
- `N_LANES`, 16: lanes per beat.
- `WI`, 8: input/output element width (signed).
- `EMS`, 8: width of `eps_mult_i` and `right_shift_i`.
- `CW`, 16: width of the GELU constants `one_i`, `b_i`, `c_i`.
- `PW`, 32: pre-requant internal width. Must satisfy `PW ≥ 2*CW+WI+2`.
- `SCW`, 16: saturation counter width.
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `valid_i` in 1: input beat valid.
- `ready_o` out 1: input beat accepted when `valid_i & ready_o`.
- `data_i` in `N_LANES*WI`: packed signed lanes; lane k is `[k*WI +: WI]`.
- `mode_i` in 2: activation mode. 0 = identity, 1 = ReLU, 2 = GELU, 3 = reserved (treated as identity).
- `one_i`, `b_i`, `c_i` in `CW` each: signed GELU constants.
- `eps_mult_i`, `right_shift_i` in `EMS` each: requant multiplier and shift. The shift is used as unsigned, range 0..`PW+EMS-1`.
- `add_i` in `WI`: signed requant offset.
- `valid_o` out 1: output beat valid.
- `ready_i` in 1: downstream ready.
- `data_o` out `N_LANES*WI`: packed signed results.
- `clear_i` in 1: synchronous clear of `sat_count_o`.
- `sat_count_o` out `SCW`: count of saturated lane results.

## Operation
- Config ports (`mode_i`, constants, `eps_mult_i`, `right_shift_i`, `add_i`) are sampled on input acceptance and travel with the beat. Changing them never affects in-flight beats.
- Per lane, x = signed lane value.
- Identity: p = sext(x).
- ReLU: p = x < 0 ? 0 : x.
- GELU: all arithmetic is signed at `PW`.
  - xc = max(x, −2^(WI−1)+1).
  - s = (x < 0) ? −1 : 1.
  - a = |xc|, clipped to at most −b.
  - L = (a+b)² + c.
  - p = x · (s·L + one).
- Requant:
  - prod = p · eps_mult at `PW+EMS` bits.
  - sh = prod >>> right_shift (arithmetic).
  - If right_shift > 0 and prod[right_shift−1] = 1, then sh += 1.
  - r = sh + sext(add).
- Saturation: r > 2^(WI−1)−1 gives 2^(WI−1)−1; r < −2^(WI−1) gives −2^(WI−1); otherwise r[WI−1:0].
- Counter: `sat_count_o` increases by the number of saturated lanes in each beat that leaves stage 3 (`valid_o & ready_i`). It sticks at 2^SCW−1 and never wraps.
- `clear_i` zeroes the counter. If a clear and a counted beat happen in the same cycle, the count becomes that beat's saturated-lane count.

## Timing
- Stage 1 registers the GELU polynomial result L (or p directly for identity/ReLU), together with x and the config.
- Stage 2 registers prod.
- Stage 3 registers the saturated result, which drives `data_o` and `valid_o`.
- Latency: 3 cycles from acceptance to `valid_o` when there is no stall. Throughput is 1 beat/cycle.
- Each stage n holds a valid bit vn. Stage n loads when it is empty or its downstream stage advances (full bubble collapse).
- adv3 = `ready_i`, which is also asserted whenever v3 = 0.
- `ready_o` = ~v1 | (~v2 | ~v3 | `ready_i`), i.e. stage 1 can move.
- `ready_o` is combinational from `ready_i`. No other comb path runs from input to output.
- Under stall `data_o` is stable. While `valid_o` = 1 and `ready_i` = 0, `valid_o` stays 1.
- Holding `ready_i` low with continuous input: 3 beats are accepted, then `ready_o` = 0 until `ready_i` rises.
- Reset values:
  - all vn = 0, so `valid_o` = 0;
  - `data_o` = 0;
  - `sat_count_o` = 0;
  - `ready_o` = 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight beats, with no output on the following cycle.

## Test plan
Unless stated, beats use `WI`=8, `EMS`=8, lane 0 shown, other lanes random and checked against a reference model.
- Identity, `eps_mult`=3, `shift`=1, `add`=0, x = 10 and x = 11 → outputs 15 and 17 (rounding bit applied). `valid_o` rises 3 cycles after acceptance.
- Identity, `eps`=4, `shift`=0, `add`=0, x = 100 and x = −100 on two lanes → 127 and −128; `sat_count_o` increments by 2. Then `clear_i` → `sat_count_o` = 0.
- ReLU, `eps`=1, `shift`=0, `add`=7, x = −5 and x = 9 → 7 and 16.
- GELU, `one`=2, `b`=−4, `c`=1, `eps`=1, `shift`=0, `add`=0, x = 2, −3, 6 → 14, 0, 18. Also x = −128 → clipped path, no overflow, matches the model.
- Backpressure: stream 20 beats with alternating modes and config. `ready_i` follows a pseudo-random pattern, including 5 cycles low. Check no loss, no duplication, in-order delivery, each beat using its own config, and `data_o` stable while stalled.
- Reset asserted with 3 beats in flight → next cycle `valid_o` = 0 and `sat_count_o` = 0. A following beat completes in 3 cycles.
